// File: rtl/vx_wnd_spill_fill_pkg.sv
// Shared window spill/fill types and constants, also used by the window-decode unit.
package vx_wnd_spill_fill_pkg;

    localparam int unsigned WND_O             = 20;
    localparam int unsigned WND_BYTES_PER_REG = 4;

    typedef enum logic {
        WndSpill = 1'b0,
        WndFill  = 1'b1
    } wnd_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StSRd,
        StSCap,
        StSWr,
        StFRq,
        StFWait,
        StFWb,
        StDone
    } wnd_state_e;

endpackage

// File: rtl/vx_wnd_spill_fill_if.sv
// Request, register-file, memory and completion signals of the window spill/fill sequencer.
interface vx_wnd_spill_fill_if #(
    parameter int unsigned N      = 8,
    parameter int unsigned W      = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_op;
    logic [W-1:0]      req_warp;
    logic [N-W-1:0]    req_base;
    logic [ADDR_W-1:0] req_addr;

    logic              rf_rd_en;
    logic [N-1:0]      rf_rd_addr;
    logic [DATA_W-1:0] rf_rd_data;
    logic              rf_wr_en;
    logic [N-1:0]      rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_data;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;

    logic              done_valid;
    logic [W-1:0]      done_warp;
    logic              busy;

    // Environment side: window-decode, register file, LSU and warp scheduler.
    modport master (
        output req_valid, req_op, req_warp, req_base, req_addr,
        input  req_ready,
        input  rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
        output rf_rd_data,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  done_valid, done_warp, busy
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_op, req_warp, req_base, req_addr,
        output req_ready,
        output rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
        input  rf_rd_data,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output done_valid, done_warp, busy
    );

endinterface

// File: rtl/vx_wnd_spill_fill_addr_gen.sv
// Running register index, memory word address and transfer counter for one spill/fill.
module vx_wnd_spill_fill_addr_gen
    import vx_wnd_spill_fill_pkg::*;
#(
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned O      = WND_O
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [IDX_W-1:0]  base,
    input  logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              last
);

    localparam int unsigned CNT_W = (O > 1) ? $clog2(O) : 1;

    logic [IDX_W-1:0]  idx_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;

    // Index wraps within the warp slice purely through the IDX_W-bit adder.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= '0;
            addr_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            idx_q  <= base;
            addr_q <= addr & ~ADDR_W'(3);
            cnt_q  <= '0;
        end else if (advance) begin
            idx_q  <= idx_q + IDX_W'(1);
            addr_q <= addr_q + ADDR_W'(WND_BYTES_PER_REG);
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    assign idx      = idx_q;
    assign mem_addr = addr_q;
    assign last     = (cnt_q == CNT_W'(O - 1));

endmodule

// File: rtl/vx_wnd_spill_fill.sv
// Register-window spill/fill sequencer: moves O registers of one warp between RF and memory.
module vx_wnd_spill_fill
    import vx_wnd_spill_fill_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned W      = 2,
    parameter int unsigned O      = WND_O,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input logic               clk,
    input logic               reset,
    vx_wnd_spill_fill_if.slave bus
);

    localparam int unsigned IDX_W = N - W;

    wnd_state_e        state_q, state_d;
    logic [W-1:0]      warp_q;
    logic [DATA_W-1:0] data_q;

    logic              accept;
    logic              advance;
    logic              last;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] mem_addr;

    assign accept  = bus.req_valid && (state_q == StIdle);
    // Step to the next register only after a transfer finishes and more remain.
    assign advance = !last && (((state_q == StSWr) && bus.mem_req_ready) || (state_q == StFWb));

    vx_wnd_spill_fill_addr_gen #(
        .IDX_W  (IDX_W),
        .ADDR_W (ADDR_W),
        .O      (O)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .advance  (advance),
        .base     (bus.req_base),
        .addr     (bus.req_addr),
        .idx      (idx),
        .mem_addr (mem_addr),
        .last     (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            warp_q <= '0;
            data_q <= '0;
        end else begin
            if (accept) begin
                warp_q <= bus.req_warp;
            end
            if (state_q == StSCap) begin
                data_q <= bus.rf_rd_data;
            end else if ((state_q == StFWait) && bus.mem_rsp_valid) begin
                data_q <= bus.mem_rsp_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    state_d = (wnd_op_e'(bus.req_op) == WndFill) ? StFRq : StSRd;
                end
            end
            StSRd:   state_d = StSCap;
            StSCap:  state_d = StSWr;
            StSWr: begin
                if (bus.mem_req_ready) begin
                    state_d = last ? StDone : StSRd;
                end
            end
            StFRq: begin
                if (bus.mem_req_ready) begin
                    state_d = StFWait;
                end
            end
            StFWait: begin
                if (bus.mem_rsp_valid) begin
                    state_d = StFWb;
                end
            end
            StFWb:   state_d = last ? StDone : StFRq;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Address and data outputs are zero whenever their strobe is low.
    always_comb begin
        bus.req_ready     = 1'b0;
        bus.rf_rd_en      = 1'b0;
        bus.rf_rd_addr    = '0;
        bus.rf_wr_en      = 1'b0;
        bus.rf_wr_addr    = '0;
        bus.rf_wr_data    = '0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_rw    = 1'b0;
        bus.mem_req_addr  = '0;
        bus.mem_req_data  = '0;
        bus.done_valid    = 1'b0;
        bus.done_warp     = '0;
        bus.busy          = (state_q != StIdle);
        unique case (state_q)
            StIdle: bus.req_ready = 1'b1;
            StSRd: begin
                bus.rf_rd_en   = 1'b1;
                bus.rf_rd_addr = {warp_q, idx};
            end
            StSWr: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_rw    = 1'b1;
                bus.mem_req_addr  = mem_addr;
                bus.mem_req_data  = data_q;
            end
            StFRq: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = mem_addr;
            end
            StFWb: begin
                bus.rf_wr_en   = 1'b1;
                bus.rf_wr_addr = {warp_q, idx};
                bus.rf_wr_data = data_q;
            end
            StDone: begin
                bus.done_valid = 1'b1;
                bus.done_warp  = warp_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/vx_wnd_spill_fill.md
Name: VX_wnd_spill_fill

Overview:
Per-core sequencer that spills a register window to memory or fills it back from memory. It runs when the window-decode stage deschedules a warp on window overflow or underflow. It sits between the window-decode unit / warp scheduler (request side) and the register file plus the LSU memory port. When an operation completes, it signals the warp scheduler to reschedule the warp. One operation is in flight at a time.

Parameters:
N, 8, log2 of total physical vector registers; the per-warp slice is 2^(N-W) entries.
W, 2, log2 of number of warps.
O, 20, registers per window ("in" + "local"); the number of transfers per operation.
ADDR_W, 32, memory byte-address width.
DATA_W, 32, register and memory data width.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  spill/fill request from window-decode unit
req_ready  out  1  high only in IDLE
req_op  in  1  0 = spill (RF to memory), 1 = fill (memory to RF)
req_warp  in  W  target warp
req_base  in  N-W  first register index within the warp slice
req_addr  in  ADDR_W  memory base byte address; bits [1:0] forced to 0 internally
rf_rd_en  out  1  register-file read strobe
rf_rd_addr  out  N  {warp, index}
rf_rd_data  in  DATA_W  valid exactly one cycle after rf_rd_en
rf_wr_en  out  1  register-file write strobe
rf_wr_addr  out  N  {warp, index}
rf_wr_data  out  DATA_W  write data
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_req_rw  out  1  1 = write, 0 = read
mem_req_addr  out  ADDR_W  word address, byte-granular
mem_req_data  out  DATA_W  store data
mem_rsp_valid  in  1  read response, in order; no ready (always accepted)
mem_rsp_data  in  DATA_W  read data
done_valid  out  1  one-cycle completion pulse to warp scheduler
done_warp  out  W  warp whose operation completed
busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, counter = 0.
  - All valid/enable outputs = 0; all addr/data outputs = 0; req_ready = 1.
- Accept: on a cycle with req_valid && req_ready, latch op, warp, base, addr and clear cnt; next state is S_RD (spill) or F_RQ (fill).
- Spill FSM, per register i:
  - S_RD (1 cycle): rf_rd_en = 1, rf_rd_addr = {warp, (base+i) mod 2^(N-W)}.
  - S_CAP (1 cycle): latch rf_rd_data into data_q.
  - S_WR: mem_req_valid = 1, rw = 1, addr = addr_q + 4*i, data = data_q. Held stable until mem_req_ready.
  - On handshake: if i == O-1 go to DONE, else i++ and go to S_RD.
- Fill FSM, per register i:
  - F_RQ: mem_req_valid = 1, rw = 0, addr = addr_q + 4*i, held until ready.
  - F_WAIT: wait for mem_rsp_valid, latch data.
  - F_WB (1 cycle): rf_wr_en = 1 to {warp, (base+i) mod 2^(N-W)}.
  - Then: if i == O-1 go to DONE, else i++ and go to F_RQ.
- DONE (1 cycle): done_valid = 1, done_warp = warp_q, req_ready = 0. Then IDLE.
- Latency: minimum 3 cycles per register. With ready always high (and, for fill, the response one cycle after the handshake), done_valid asserts exactly 3*O+1 cycles after the accept edge.
- Index arithmetic: wraps modulo 2^(N-W); the warp field of the RF address never changes. Memory address increments are mod 2^ADDR_W.
- Counter: width $clog2(O). No transfer is issued for i >= O.
- mem_rsp_valid outside F_WAIT: ignored; no state change.
- req_valid while busy: not accepted, no side effects; the requester holds it.
- Reset mid-operation: abort immediately at the next edge. Drop mem_req_valid; no done pulse, no further RF writes; a partial window is left as-is.
- mem_req_valid must never deassert before a handshake (except on reset). mem_req_addr and mem_req_data are stable while valid && !ready.

Decomposition:
- Shared package VX_wnd_pkg:
  - typedef wnd_op_e {WND_SPILL, WND_FILL}
  - state enum {IDLE, S_RD, S_CAP, S_WR, F_RQ, F_WAIT, F_WB, DONE}
  - constants WND_O and WND_BYTES_PER_REG = 4, shared with the window-decode unit
- One natural sub-module, VX_wnd_addr_gen: holds base, addr and cnt. Produces the wrapped RF index, the memory address and the last flag on an advance strobe.

Test Plan:
- Spill, warp 1, base 10, addr 0x1000, mem_req_ready = 1 → 20 writes to 0x1000..0x104C with data from RF {01,10}..{01,29} in order; done_valid with done_warp = 1 at accept + 61 cycles.
- Wrap: spill, warp 3, base 60 → RF indices 60..63 then 0..15, all with warp field 3; memory addresses contiguous.
- Backpressure: mem_req_ready low for 5 cycles on transfer 7 → addr/data/valid held stable; total latency grows by exactly 5; no duplicate writes.
- Fill, warp 2, base 0, addr 0x2000, response 1 cycle after handshake; a stray mem_rsp_valid during F_RQ → 20 RF writes of the response data to {10,0..19}; stray response ignored; done at accept + 61.
- Request during busy: second req_valid held → req_ready = 0 until the cycle after DONE; second op accepted then.
- Reset asserted during S_WR of transfer 12 → next cycle mem_req_valid = 0, busy = 0, req_ready = 1; no done_valid pulse.
